// File: rtl/cotm32_pkg.sv
// Shared core-wide types and constants, including the writeback request format
// and the one-hot register decoder used for pending-write tracking.
package cotm32_pkg;

    localparam int XLEN          = 32;
    localparam int NUM_REGS      = 32;
    localparam int REG_AW        = $clog2(NUM_REGS);
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] dec(input logic [REG_AW-1:0] a);
        logic [NUM_REGS-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Holding queue for secondary writeback results. Entries stay packed from slot 0
// (the head), so invalidated entries vanish the same cycle and never stall a pop.
module wb_fifo
    import cotm32_pkg::*;
#(
    parameter  int DEPTH = WB_FIFO_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  wb_req_t                       i_push_req,
    input  logic                          i_pop,
    input  logic                          i_inv,
    input  logic [REG_AW-1:0]             i_inv_addr,
    output logic                          o_head_valid,
    output wb_req_t                       o_head,
    output logic                          o_full,
    output logic [CW-1:0]                 o_count,
    output logic [DEPTH-1:0]              o_nxt_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  o_nxt_addr
);

    wb_req_t [DEPTH-1:0] mem_q;
    wb_req_t [DEPTH-1:0] nxt_mem;
    logic    [DEPTH-1:0] vld_q;
    logic    [DEPTH-1:0] nxt_vld;
    logic                keep;
    int                  kept;

    // Survivors (not popped, not squashed) are re-packed in order, then the push lands behind them.
    always_comb begin
        nxt_mem = mem_q;
        nxt_vld = '0;
        keep    = 1'b0;
        kept    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            keep = vld_q[i] && !(i_pop && i == 0) && !(i_inv && mem_q[i].addr == i_inv_addr);
            if (keep) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (kept == j) begin
                        nxt_mem[j] = mem_q[i];
                        nxt_vld[j] = 1'b1;
                    end
                end
                kept = kept + 1;
            end
        end
        if (i_push) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (kept == j) begin
                    nxt_mem[j] = i_push_req;
                    nxt_vld[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q <= '0;
            vld_q <= '0;
        end else begin
            mem_q <= nxt_mem;
            vld_q <= nxt_vld;
        end
    end

    always_comb begin
        o_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_count = o_count + CW'(vld_q[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_nxt_addr[i] = nxt_mem[i].addr;
        end
    end

    assign o_head_valid = vld_q[0];
    assign o_head       = mem_q[0];
    assign o_full       = vld_q[DEPTH-1];
    assign o_nxt_valid  = nxt_vld;

endmodule

// File: rtl/writeback_arbiter.sv
// Owns the register-file write port: merges the never-stalled primary path with the
// handshaked secondary path into one registered write, tracking in-flight targets.
module writeback_arbiter
    import cotm32_pkg::*;
#(
    parameter  int N_REGS     = NUM_REGS,
    parameter  int FIFO_DEPTH = WB_FIFO_DEPTH,
    localparam int AW         = $clog2(N_REGS),
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_p_we,
    input  logic [AW-1:0]     i_p_waddr,
    input  logic [XLEN-1:0]   i_p_wdata,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [AW-1:0]     i_s_waddr,
    input  logic [XLEN-1:0]   i_s_wdata,
    output logic              o_we,
    output logic [AW-1:0]     o_waddr,
    output logic [XLEN-1:0]   o_wdata,
    output logic [N_REGS-1:0] o_pending,
    output logic [CW-1:0]     o_fifo_count
);

    logic                             p_win;
    logic                             s_acc;
    logic                             s_live;
    logic                             fifo_pop;
    logic                             fifo_push;
    logic                             bypass;
    logic                             win;
    wb_req_t                          win_req;
    logic                             head_valid;
    wb_req_t                          head;
    logic                             fifo_full;
    logic [FIFO_DEPTH-1:0]            fifo_nxt_vld;
    logic [FIFO_DEPTH-1:0][REG_AW-1:0] fifo_nxt_addr;
    logic [N_REGS-1:0]                pend_nxt;

    // Secondary handshake: a result transfers on any edge where i_s_valid && o_s_ready.
    // o_s_ready depends only on stored FIFO occupancy, so a full FIFO refuses even
    // when it is popping in the same cycle.
    assign o_s_ready = !fifo_full;
    assign s_acc     = i_s_valid && o_s_ready;
    assign p_win     = i_p_we && (i_p_waddr != '0);

    // Secondary writes to x0, or to the register the younger primary overwrites now, are dropped.
    assign s_live    = s_acc && (i_s_waddr != '0) && !(p_win && i_s_waddr == i_p_waddr);
    assign fifo_pop  = !p_win && head_valid;
    assign bypass    = !p_win && !head_valid && s_live;
    assign fifo_push = s_live && !bypass;
    assign win       = p_win || head_valid || s_live;

    always_comb begin
        win_req = '{addr: i_s_waddr, data: i_s_wdata};
        if (p_win) begin
            win_req = '{addr: i_p_waddr, data: i_p_wdata};
        end else if (head_valid) begin
            win_req = head;
        end
    end

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (fifo_push),
        .i_push_req   ('{addr: i_s_waddr, data: i_s_wdata}),
        .i_pop        (fifo_pop),
        .i_inv        (p_win),
        .i_inv_addr   (i_p_waddr),
        .o_head_valid (head_valid),
        .o_head       (head),
        .o_full       (fifo_full),
        .o_count      (o_fifo_count),
        .o_nxt_valid  (fifo_nxt_vld),
        .o_nxt_addr   (fifo_nxt_addr)
    );

    // Pending is built from next-cycle contents so it lines up with the registered outputs.
    always_comb begin
        pend_nxt = '0;
        if (win) begin
            pend_nxt = dec(win_req.addr);
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_nxt_vld[i]) begin
                pend_nxt = pend_nxt | dec(fifo_nxt_addr[i]);
            end
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_we      <= 1'b0;
            o_waddr   <= '0;
            o_wdata   <= '0;
            o_pending <= '0;
        end else begin
            o_we      <= win;
            o_pending <= pend_nxt;
            if (win) begin
                o_waddr <= win_req.addr;
                o_wdata <= win_req.data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a queue model.
module tb_writeback_arbiter;
    import cotm32_pkg::*;

    localparam int AW    = $clog2(NUM_REGS);
    localparam int DEPTH = WB_FIFO_DEPTH;
    localparam int W     = AW + XLEN;

    logic                clk;
    logic                rst_n;
    logic                p_we;
    logic [AW-1:0]       p_waddr;
    logic [XLEN-1:0]     p_wdata;
    logic                s_valid;
    logic                s_ready;
    logic [AW-1:0]       s_waddr;
    logic [XLEN-1:0]     s_wdata;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NUM_REGS-1:0] pending;
    logic [1:0]          fifo_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: queued secondary results (oldest first) and the expected output stage.
    logic [W-1:0]    exp_q[$];
    logic            m_we;
    logic [AW-1:0]   m_waddr;
    logic [XLEN-1:0] m_wdata;

    writeback_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_p_we       (p_we),
        .i_p_waddr    (p_waddr),
        .i_p_wdata    (p_wdata),
        .i_s_valid    (s_valid),
        .o_s_ready    (s_ready),
        .i_s_waddr    (s_waddr),
        .i_s_wdata    (s_wdata),
        .o_we         (we),
        .o_waddr      (waddr),
        .o_wdata      (wdata),
        .o_pending    (pending),
        .o_fifo_count (fifo_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic drv(input logic pw, input logic [AW-1:0] pa, input logic [XLEN-1:0] pd,
                       input logic sv, input logic [AW-1:0] sa, input logic [XLEN-1:0] sd);
        p_we    = pw;
        p_waddr = pa;
        p_wdata = pd;
        s_valid = sv;
        s_waddr = sa;
        s_wdata = sd;
    endtask

    task automatic idle();
        drv(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: fixed priority primary > oldest queued > fresh secondary.
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            logic acc;
            acc = s_valid && (exp_q.size() < DEPTH);
            if (p_we && p_waddr != 0) begin
                m_we    = 1'b1;
                m_waddr = p_waddr;
                m_wdata = p_wdata;
                for (int i = exp_q.size() - 1; i >= 0; i--) begin
                    if (exp_q[i][W-1:XLEN] == p_waddr) exp_q.delete(i);
                end
                if (acc && s_waddr != 0 && s_waddr != p_waddr) exp_q.push_back({s_waddr, s_wdata});
            end else if (exp_q.size() > 0) begin
                logic [W-1:0] h;
                h       = exp_q.pop_front();
                m_we    = 1'b1;
                m_waddr = h[W-1:XLEN];
                m_wdata = h[XLEN-1:0];
                if (acc && s_waddr != 0) exp_q.push_back({s_waddr, s_wdata});
            end else if (acc && s_waddr != 0) begin
                m_we    = 1'b1;
                m_waddr = s_waddr;
                m_wdata = s_wdata;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Scoreboard compare, every cycle away from the active edge
    initial begin
        forever begin
            logic [NUM_REGS-1:0] exp_pend;
            @(negedge clk);
            exp_pend = '0;
            if (m_we) exp_pend[m_waddr] = 1'b1;
            foreach (exp_q[i]) exp_pend[exp_q[i][W-1:XLEN]] = 1'b1;
            exp_pend[0] = 1'b0;
            cmp("m_we",      we,         m_we);
            cmp("m_waddr",   waddr,      m_waddr);
            cmp("m_wdata",   wdata,      m_wdata);
            cmp("m_pending", pending,    exp_pend);
            cmp("m_count",   fifo_count, exp_q.size());
            cmp("m_ready",   s_ready,    exp_q.size() < DEPTH);
        end
    end

    initial begin
        logic [AW-1:0] got[$];
        int sidx;

        rst_n = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp("rst_we",      we, 0);
        cmp("rst_count",   fifo_count, 0);
        cmp("rst_pending", pending, 0);
        cmp("rst_ready",   s_ready, 1);

        // Primary only
        drv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        tick();
        cmp("prim_we",    we, 1);
        cmp("prim_waddr", waddr, 5);
        cmp("prim_wdata", wdata, 32'hDEADBEEF);
        cmp("prim_pend",  pending, 32'h0000_0020);
        idle();
        tick();
        cmp("prim_we_off",   we, 0);
        cmp("prim_pend_off", pending, 0);
        cmp("prim_hold",     waddr, 5);

        // Collision: primary wins, secondary queued then written next cycle
        drv(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        tick();
        idle();
        cmp("col_a_addr", waddr, 3);
        cmp("col_a_data", wdata, 32'h11);
        cmp("col_a_pend", pending, 32'h0000_0088);
        cmp("col_a_cnt",  fifo_count, 1);
        tick();
        cmp("col_b_we",   we, 1);
        cmp("col_b_addr", waddr, 7);
        cmp("col_b_data", wdata, 32'h22);
        cmp("col_b_pend", pending, 32'h0000_0080);
        tick();
        cmp("col_c_pend", pending, 0);

        // Backpressure: four busy primary cycles against three secondary offers
        sidx = 0;
        for (int c = 0; c < 12; c++) begin
            drv(c < 4, 5'(11 + c), 32'(32'h100 + c), sidx < 3, 5'(8 + sidx), 32'(32'h800 + sidx));
            if (c == 2) cmp("bp_ready_drop", s_ready, 0);
            if (sidx < 3 && s_ready) sidx++;
            tick();
            if (we && waddr >= 8 && waddr <= 10) got.push_back(waddr);
        end
        idle();
        cmp("bp_all_sent", sidx, 3);
        cmp("bp_written",  got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) cmp("bp_order", got[i], 8 + i);

        // WAW squash: queued x4=AA overwritten by primary x4=BB
        drv(1'b1, 5'd2, 32'h1, 1'b1, 5'd4, 32'hAA);
        tick();
        cmp("waw_queued", fifo_count, 1);
        drv(1'b1, 5'd4, 32'hBB, 1'b0, '0, '0);
        tick();
        cmp("waw_data", wdata, 32'hBB);
        cmp("waw_cnt",  fifo_count, 0);
        cmp("waw_pend", pending, 32'h0000_0010);
        idle();
        tick();
        cmp("waw_no_aa",    we, 0);
        cmp("waw_pend_off", pending, 0);

        // x0 handling
        drv(1'b0, '0, '0, 1'b1, 5'd0, 32'h77);
        cmp("x0_ready", s_ready, 1);
        tick();
        cmp("x0_s_we",  we, 0);
        cmp("x0_s_cnt", fifo_count, 0);
        drv(1'b1, 5'd2, 32'h2, 1'b1, 5'd6, 32'h66);
        tick();
        drv(1'b1, 5'd0, 32'h99, 1'b0, '0, '0);
        tick();
        cmp("x0_p_we",   we, 1);
        cmp("x0_p_addr", waddr, 6);
        cmp("x0_p_data", wdata, 32'h66);

        // Reset mid-stream with two queued entries
        drv(1'b1, 5'd2, 32'h3, 1'b1, 5'd8, 32'h5);
        tick();
        drv(1'b1, 5'd3, 32'h4, 1'b1, 5'd9, 32'h6);
        tick();
        idle();
        cmp("mrst_pre_cnt", fifo_count, 2);
        #2 rst_n = 1'b0;
        #1;
        cmp("mrst_we",    we, 0);
        cmp("mrst_pend",  pending, 0);
        cmp("mrst_count", fifo_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp("mrst_ready", s_ready, 1);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            drv($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        idle();
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
